slot_arbiter: RTL and testbench

// - Parametrised TDM bus arbiter: time-slices the shared Wishbone bus between NUM_CTRL controllers and the CPU.
// - Each slot owner comes from a slot table. Idle controller slots can be donated round-robin to other requesters.
// - Adds transaction tracking, an ack timeout and abort-on-CPU-slot. Sits between the SPI/video/etc. controllers and the memory/IO bus.

---
 rtl/common_pkg.sv | 18 +
 rtl/arb_rr_pick.sv | 41 ++++
 rtl/slot_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_slot_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared bus widths, arbiter state type and owner encoding helper for the
// memory/IO bus fabric.
package common_pkg;

    localparam int WB_ADDR_WIDTH = 24;
    localparam int DATA_WIDTH    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Owner code that marks a slot as belonging to the CPU.
    function automatic int ARB_CPU_OWNER(input int n);
        return n;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: lowest set request at or after ptr,
// wrapping to the lowest set request below ptr.
module arb_rr_pick
    import common_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;
    logic          found_hi;
    logic          found_lo;

    // Descending scan so the last hit (the lowest index) wins in each half.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IW'(i) >= ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = IW'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = IW'(i);
                end
            end
        end
        valid = found_hi | found_lo;
        idx   = found_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/slot_arbiter.sv
// TDM Wishbone arbiter: slot table ownership, idle-slot donation, single
// outstanding transaction with ack timeout and abort on CPU slots.
module slot_arbiter
    import common_pkg::*;
#(
    parameter int NUM_CTRL    = 2,
    parameter int SLOT_BITS   = 3,
    parameter logic [(2**SLOT_BITS)*$clog2(NUM_CTRL+1)-1:0] SLOT_MAP = 16'h5A00,
    parameter bit DONATE      = 1'b1,
    parameter int ACK_TIMEOUT = 7
) (
    input  logic                              wb_clock_i,
    input  logic                              wb_reset_ni,
    input  logic                              clk8_en_i,
    input  logic [NUM_CTRL*WB_ADDR_WIDTH-1:0] wbc_addr_i,
    input  logic [NUM_CTRL*DATA_WIDTH-1:0]    wbc_data_i,
    input  logic [NUM_CTRL-1:0]               wbc_we_i,
    input  logic [NUM_CTRL-1:0]               wbc_cycle_i,
    input  logic [NUM_CTRL-1:0]               wbc_strobe_i,
    output logic [NUM_CTRL-1:0]               wbc_stall_o,
    output logic [NUM_CTRL-1:0]               wbc_ack_o,
    output logic [NUM_CTRL-1:0]               wbc_err_o,
    output logic [WB_ADDR_WIDTH-1:0]          wb_addr_o,
    output logic [DATA_WIDTH-1:0]             wb_data_o,
    output logic                              wb_we_o,
    output logic                              wb_cycle_o,
    output logic                              wb_strobe_o,
    input  logic                              wb_stall_i,
    input  logic                              wb_ack_i,
    output logic                              cpu_grant_en_o,
    output logic [SLOT_BITS-1:0]              slot_o
);

    localparam int SLOTS = 2**SLOT_BITS;
    localparam int CW    = $clog2(NUM_CTRL + 1);
    localparam int IW    = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CPU_OWNER = CW'(ARB_CPU_OWNER(NUM_CTRL));

    function automatic logic [NUM_CTRL-1:0] idx_mask(input logic [IW-1:0] idx);
        logic [NUM_CTRL-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (idx == IW'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [SLOT_BITS-1:0] slot_reg;
    logic                 clk8_en_delay_reg;
    arb_state_t           state_reg, state_next;
    logic [IW-1:0]        sel_reg, sel_next;
    logic [IW-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [TW-1:0]        timer_reg, timer_next;

    logic [CW-1:0] slot_owner [SLOTS];
    logic [CW-1:0] owner;
    logic          en;
    logic          cpu_slot;
    logic          owner_is_ctrl;
    logic          owner_req;
    logic [IW-1:0] owner_idx;
    logic [IW-1:0] rr_idx;
    logic          rr_valid;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          donated;
    logic [IW-1:0] bus_idx;
    logic          bus_active;

    logic [WB_ADDR_WIDTH-1:0] mux_addr;
    logic [DATA_WIDTH-1:0]    mux_data;
    logic                     mux_we;
    logic                     mux_stb;
    logic                     mux_cyc;

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_owner
        assign slot_owner[gi] = SLOT_MAP[gi*CW +: CW];
    end

    assign owner          = slot_owner[slot_reg];
    assign en             = clk8_en_delay_reg;
    assign cpu_slot       = (owner == CPU_OWNER);
    assign cpu_grant_en_o = en & cpu_slot;
    assign slot_o         = slot_reg;

    always_comb begin
        owner_is_ctrl = 1'b0;
        owner_req     = 1'b0;
        owner_idx     = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (owner == CW'(i)) begin
                owner_is_ctrl = 1'b1;
                owner_req     = wbc_cycle_i[i];
                owner_idx     = IW'(i);
            end
        end
    end

    arb_rr_pick #(
        .N  (NUM_CTRL),
        .IW (IW)
    ) u_rr_pick (
        .req   (wbc_cycle_i),
        .ptr   (rr_ptr_reg),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = owner_idx;
        donated    = 1'b0;
        if (en && owner_is_ctrl) begin
            if (owner_req) begin
                pick_valid = 1'b1;
            end else if (DONATE && rr_valid) begin
                pick_valid = 1'b1;
                pick_idx   = rr_idx;
                donated    = 1'b1;
            end
        end
    end

    assign bus_idx = (state_reg == BUSY) ? sel_reg : pick_idx;

    always_comb begin
        mux_addr = '0;
        mux_data = '0;
        mux_we   = 1'b0;
        mux_stb  = 1'b0;
        mux_cyc  = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (bus_idx == IW'(i)) begin
                mux_addr = wbc_addr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                mux_data = wbc_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                mux_we   = wbc_we_i[i];
                mux_stb  = wbc_strobe_i[i];
                mux_cyc  = wbc_cycle_i[i];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        timer_next  = timer_reg;
        bus_active  = 1'b0;
        wb_strobe_o = 1'b0;
        wbc_stall_o = '1;
        wbc_ack_o   = '0;
        wbc_err_o   = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    bus_active  = 1'b1;
                    wb_strobe_o = mux_stb;
                    wbc_stall_o = ~idx_mask(pick_idx) | (idx_mask(pick_idx) & {NUM_CTRL{wb_stall_i}});
                    if (donated) begin
                        rr_ptr_next = (pick_idx == IW'(NUM_CTRL - 1)) ? '0 : pick_idx + 1'b1;
                    end
                    if (mux_stb && !wb_stall_i) begin
                        if (wb_ack_i) begin
                            wbc_ack_o = idx_mask(pick_idx);
                        end else begin
                            state_next = BUSY;
                            sel_next   = pick_idx;
                            timer_next = '0;
                        end
                    end
                end
            end
            BUSY: begin
                timer_next = timer_reg + 1'b1;
                if (!mux_cyc) begin
                    state_next = IDLE;
                end else begin
                    // The CPU slot always takes the bus, even if the ack lands now.
                    bus_active = ~(en & cpu_slot);
                    if (wb_ack_i) begin
                        wbc_ack_o  = idx_mask(sel_reg);
                        state_next = IDLE;
                    end else if (en && cpu_slot) begin
                        wbc_err_o  = idx_mask(sel_reg);
                        state_next = IDLE;
                    end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
                        wbc_err_o  = idx_mask(sel_reg);
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wb_cycle_o = bus_active;
    assign wb_addr_o  = bus_active ? mux_addr : '0;
    assign wb_data_o  = bus_active ? mux_data : '0;
    assign wb_we_o    = bus_active & mux_we;

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            slot_reg          <= '1;
            clk8_en_delay_reg <= 1'b0;
            state_reg         <= IDLE;
            sel_reg           <= '0;
            rr_ptr_reg        <= '0;
            timer_reg         <= '0;
        end else begin
            if (clk8_en_i) slot_reg <= slot_reg + 1'b1;
            clk8_en_delay_reg <= clk8_en_i;
            state_reg         <= state_next;
            sel_reg           <= sel_next;
            rr_ptr_reg        <= rr_ptr_next;
            timer_reg         <= timer_next;
        end
    end

endmodule

// File: tb/tb_slot_arbiter.sv
// Bench for slot_arbiter: directed slot/ack/donation/timeout/abort/reset
// scenarios plus randomized traffic against a reference model.
module tb_slot_arbiter;
    import common_pkg::*;

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int TO_A = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk8_en = 1'b0;
    logic [2*AW-1:0] wbc_addr = '0;
    logic [2*DW-1:0] wbc_data = '0;
    logic [1:0] wbc_we = '0, wbc_cyc = '0, wbc_stb = '0;
    logic wb_stall = 1'b0, wb_ack = 1'b0;

    logic [1:0] a_stall, a_ack, a_err, b_stall, b_ack, b_err;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic a_we, a_cyc, a_stb, a_cpu, b_we, b_cyc, b_stb, b_cpu;
    logic [2:0] a_slot, b_slot;

    int n_cmp = 0;
    int n_fail = 0;
    int tb_slot = 7;
    logic tb_en_d = 1'b0;
    int phase = 7;
    int owner_tab [8] = '{0, 0, 0, 0, 2, 2, 1, 1};

    slot_arbiter #(.NUM_CTRL(2), .SLOT_BITS(3), .SLOT_MAP(16'h5A00), .DONATE(1'b1), .ACK_TIMEOUT(TO_A)) dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .clk8_en_i(clk8_en),
        .wbc_addr_i(wbc_addr), .wbc_data_i(wbc_data), .wbc_we_i(wbc_we),
        .wbc_cycle_i(wbc_cyc), .wbc_strobe_i(wbc_stb),
        .wbc_stall_o(a_stall), .wbc_ack_o(a_ack), .wbc_err_o(a_err),
        .wb_addr_o(a_addr), .wb_data_o(a_data), .wb_we_o(a_we),
        .wb_cycle_o(a_cyc), .wb_strobe_o(a_stb), .wb_stall_i(wb_stall), .wb_ack_i(wb_ack),
        .cpu_grant_en_o(a_cpu), .slot_o(a_slot));

    slot_arbiter #(.NUM_CTRL(2), .SLOT_BITS(3), .SLOT_MAP(16'h5A00), .DONATE(1'b0), .ACK_TIMEOUT(12)) dut_nd (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .clk8_en_i(clk8_en),
        .wbc_addr_i(wbc_addr), .wbc_data_i(wbc_data), .wbc_we_i(wbc_we),
        .wbc_cycle_i(wbc_cyc), .wbc_strobe_i(wbc_stb),
        .wbc_stall_o(b_stall), .wbc_ack_o(b_ack), .wbc_err_o(b_err),
        .wb_addr_o(b_addr), .wb_data_o(b_data), .wb_we_o(b_we),
        .wb_cycle_o(b_cyc), .wb_strobe_o(b_stb), .wb_stall_i(wb_stall), .wb_ack_i(wb_ack),
        .cpu_grant_en_o(b_cpu), .slot_o(b_slot));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs may be changed right after this returns.
    task automatic next_cycle();
        @(posedge clk);
        if (rst_n) begin
            if (clk8_en) tb_slot = (tb_slot + 1) % 8;
            tb_en_d = clk8_en;
        end
        #1;
        phase = (phase + 1) % 8;
        clk8_en = (phase == 0);
    endtask

    // Returns in the cycle whose clk8_en leads into slot s.
    task automatic wait_en_into(input int s);
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            if (clk8_en && tb_slot == (s + 7) % 8) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL wait_slot_%0d: no clk8_en into slot within 200 cycles", s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_cmp++; if (a_stall !== 2'b11) begin n_fail++; $display("FAIL reset_stall: got %b want 11", a_stall); end
        n_cmp++; if (a_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", a_ack); end
        n_cmp++; if (a_err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", a_err); end
        n_cmp++; if ({a_cyc, a_stb, a_we, a_cpu} !== 4'b0) begin n_fail++; $display("FAIL reset_bus: got %b want 0000", {a_cyc, a_stb, a_we, a_cpu}); end
        n_cmp++; if (a_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", a_addr); end
        n_cmp++; if (a_slot !== 3'd7) begin n_fail++; $display("FAIL reset_slot: got %0d want 7", a_slot); end
        @(posedge clk); #1;
        rst_n = 1'b1; tb_slot = 7; tb_en_d = 1'b0; phase = 7;
    endtask

    task automatic test_cpu_grant();
        int pulses;
        logic exp;
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            next_cycle(); #2;
            exp = tb_en_d && (tb_slot == 4 || tb_slot == 5);
            if (a_cpu) pulses++;
            n_cmp++; if (a_cpu !== exp) begin n_fail++; $display("FAIL cpu_grant: cycle %0d slot %0d got %b want %b", i, tb_slot, a_cpu, exp); end
            if (tb_en_d) begin
                n_cmp++; if (a_slot !== 3'(tb_slot)) begin n_fail++; $display("FAIL slot_count: got %0d want %0d", a_slot, tb_slot); end
            end
        end
        n_cmp++; if (pulses != 4) begin n_fail++; $display("FAIL cpu_pulses: got %0d want 4", pulses); end
    endtask

    task automatic test_ack_latency();
        wait_en_into(6);
        wbc_addr[AW +: AW] = 24'h12_3456; wbc_data[DW +: DW] = 16'hBEEF; wbc_we = 2'b10;
        wbc_cyc = 2'b10; wbc_stb = 2'b10; wb_stall = 1'b0; wb_ack = 1'b0;
        next_cycle(); #2;
        n_cmp++; if ({a_cyc, a_stb} !== 2'b11) begin n_fail++; $display("FAIL ack_issue: cyc/stb got %b want 11", {a_cyc, a_stb}); end
        n_cmp++; if ({a_addr, a_data, a_we} !== {24'h12_3456, 16'hBEEF, 1'b1}) begin n_fail++; $display("FAIL ack_mux: got %h %h %b", a_addr, a_data, a_we); end
        n_cmp++; if (a_stall !== 2'b01) begin n_fail++; $display("FAIL ack_issue_stall: got %b want 01", a_stall); end
        next_cycle(); wbc_stb = 2'b00; #2;
        n_cmp++; if ({a_cyc, a_stb, a_ack, a_stall} !== 6'b10_00_11) begin n_fail++; $display("FAIL ack_busy: got %b want 100011", {a_cyc, a_stb, a_ack, a_stall}); end
        next_cycle(); wb_ack = 1'b1; #2;
        n_cmp++; if (a_ack !== 2'b10) begin n_fail++; $display("FAIL ack_route: got %b want 10", a_ack); end
        n_cmp++; if (a_stall[0] !== 1'b1) begin n_fail++; $display("FAIL ack_ctrl0_stall: got %b want 1", a_stall[0]); end
        next_cycle(); wb_ack = 1'b0; wbc_cyc = 2'b00; wbc_we = 2'b00; #2;
        n_cmp++; if ({a_ack, a_cyc} !== 3'b000) begin n_fail++; $display("FAIL ack_single: got %b want 000", {a_ack, a_cyc}); end
    endtask

    task automatic test_donate();
        int served;
        served = 0;
        wait_en_into(0);
        wbc_cyc = 2'b10; wbc_stb = 2'b10; wb_ack = 1'b1; wb_stall = 1'b0;
        for (int i = 0; i < 32; i++) begin
            next_cycle(); #2;
            if (tb_en_d) begin
                if (a_ack == 2'b10) served++;
                n_cmp++; if ({a_cyc, a_ack} !== 3'b110) begin n_fail++; $display("FAIL donate_on: slot %0d got %b want 110", tb_slot, {a_cyc, a_ack}); end
                n_cmp++; if ({b_cyc, b_ack} !== 3'b000) begin n_fail++; $display("FAIL donate_off: slot %0d got %b want 000", tb_slot, {b_cyc, b_ack}); end
            end else begin
                n_cmp++; if ({a_cyc, a_ack} !== 3'b000) begin n_fail++; $display("FAIL donate_idle: slot %0d got %b want 000", tb_slot, {a_cyc, a_ack}); end
            end
        end
        wbc_cyc = 2'b00; wbc_stb = 2'b00; wb_ack = 1'b0;
        n_cmp++; if (served != 4) begin n_fail++; $display("FAIL donate_count: got %0d want 4", served); end
    endtask

    task automatic test_timeout();
        wait_en_into(6);
        wbc_cyc = 2'b10; wbc_stb = 2'b10; wb_ack = 1'b0; wb_stall = 1'b0;
        next_cycle(); #2;
        n_cmp++; if ({a_cyc, a_stb} !== 2'b11) begin n_fail++; $display("FAIL to_issue: got %b want 11", {a_cyc, a_stb}); end
        for (int k = 1; k <= 2; k++) begin
            next_cycle(); wbc_stb = 2'b00; #2;
            n_cmp++; if ({a_cyc, a_err} !== 3'b100) begin n_fail++; $display("FAIL to_wait%0d: got %b want 100", k, {a_cyc, a_err}); end
        end
        next_cycle(); #2;
        n_cmp++; if ({a_err, a_ack} !== 4'b1000) begin n_fail++; $display("FAIL to_err: err/ack got %b want 1000", {a_err, a_ack}); end
        next_cycle(); #2;
        n_cmp++; if ({a_cyc, a_err} !== 3'b000) begin n_fail++; $display("FAIL to_release: got %b want 000", {a_cyc, a_err}); end
        wbc_cyc = 2'b00;
    endtask

    task automatic test_cpu_abort();
        wait_en_into(3);
        wbc_cyc = 2'b01; wbc_stb = 2'b01; wb_ack = 1'b0; wb_stall = 1'b0;
        next_cycle(); #2;
        n_cmp++; if ({b_cyc, b_stb} !== 2'b11) begin n_fail++; $display("FAIL abort_issue: got %b want 11", {b_cyc, b_stb}); end
        for (int k = 1; k <= 7; k++) begin
            next_cycle(); wbc_stb = 2'b00; #2;
            n_cmp++; if ({b_cyc, b_err} !== 3'b100) begin n_fail++; $display("FAIL abort_busy%0d: got %b want 100", k, {b_cyc, b_err}); end
        end
        next_cycle(); #2;
        n_cmp++; if ({b_cpu, b_cyc, b_err} !== 4'b1001) begin n_fail++; $display("FAIL abort_cpu: cpu/cyc/err got %b want 1001", {b_cpu, b_cyc, b_err}); end
        next_cycle(); wbc_cyc = 2'b00; #2;
        n_cmp++; if ({b_cyc, b_err} !== 3'b000) begin n_fail++; $display("FAIL abort_after: got %b want 000", {b_cyc, b_err}); end
    endtask

    task automatic test_reset_mid_busy();
        wait_en_into(6);
        wbc_cyc = 2'b10; wbc_stb = 2'b10; wb_ack = 1'b0; wb_stall = 1'b0;
        next_cycle();
        next_cycle(); wbc_stb = 2'b00; #2;
        n_cmp++; if (a_cyc !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", a_cyc); end
        #1; rst_n = 1'b0; #1;
        n_cmp++; if ({a_stall, a_cyc, a_err, a_ack} !== 7'b11_0_00_00) begin n_fail++; $display("FAIL rst_async: got %b want 1100000", {a_stall, a_cyc, a_err, a_ack}); end
        n_cmp++; if (a_slot !== 3'd7) begin n_fail++; $display("FAIL rst_async_slot: got %0d want 7", a_slot); end
        wbc_cyc = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1; tb_slot = 7; tb_en_d = 1'b0; phase = 7; clk8_en = 1'b0;
        next_cycle();
        next_cycle(); #2;
        n_cmp++; if ({tb_en_d, a_slot} !== 4'b1_000) begin n_fail++; $display("FAIL rst_first_slot: en/slot got %b/%0d want 1/0", tb_en_d, a_slot); end
    endtask

    task automatic test_random();
        int m_slot, m_sel, m_since, m_rr, owner, pick, who;
        logic m_en, m_busy;
        logic [1:0] e_stall, e_ack, e_err;
        logic e_cyc, e_stb, e_cpu, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        @(posedge clk); #1;
        rst_n = 1'b0; clk8_en = 1'b0; wbc_cyc = '0; wbc_stb = '0; wb_ack = 1'b0; wb_stall = 1'b0;
        #2; rst_n = 1'b1;
        m_slot = 7; m_en = 1'b0; m_busy = 1'b0; m_sel = 0; m_since = 0; m_rr = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            clk8_en = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 2; i++) if ($urandom_range(0, 7) == 0) wbc_cyc[i] = ~wbc_cyc[i];
            wbc_stb = 2'($urandom); wbc_we = 2'($urandom);
            wbc_addr = {24'($urandom), 24'($urandom)}; wbc_data = 32'($urandom);
            wb_stall = ($urandom_range(0, 3) == 0); wb_ack = ($urandom_range(0, 3) == 0);
            #2;
            owner = owner_tab[m_slot];
            e_cpu = m_en && owner == 2;
            e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00; e_cyc = 1'b0; e_stb = 1'b0; who = 0;
            if (m_busy) begin
                m_since++;
                if (!wbc_cyc[m_sel]) m_busy = 1'b0;
                else begin
                    who = m_sel; e_cyc = !e_cpu;
                    if (wb_ack) begin e_ack[m_sel] = 1'b1; m_busy = 1'b0; end
                    else if (e_cpu || m_since >= TO_A) begin e_err[m_sel] = 1'b1; m_busy = 1'b0; end
                end
            end else if (m_en && owner < 2) begin
                pick = -1;
                if (wbc_cyc[owner]) pick = owner;
                else begin
                    for (int k = 0; k < 2; k++) if (pick < 0 && wbc_cyc[(m_rr + k) % 2]) pick = (m_rr + k) % 2;
                    if (pick >= 0) m_rr = (pick + 1) % 2;
                end
                if (pick >= 0) begin
                    who = pick; e_cyc = 1'b1; e_stb = wbc_stb[pick]; e_stall[pick] = wb_stall;
                    if (e_stb && !wb_stall) begin
                        if (wb_ack) e_ack[pick] = 1'b1;
                        else begin m_busy = 1'b1; m_sel = pick; m_since = 0; end
                    end
                end
            end
            e_addr = e_cyc ? wbc_addr[who*AW +: AW] : '0;
            e_data = e_cyc ? wbc_data[who*DW +: DW] : '0;
            e_we   = e_cyc && wbc_we[who];
            n_cmp++; if (a_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall: c%0d got %b want %b", c, a_stall, e_stall); end
            n_cmp++; if (a_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack: c%0d got %b want %b", c, a_ack, e_ack); end
            n_cmp++; if (a_err !== e_err) begin n_fail++; $display("FAIL rnd_err: c%0d got %b want %b", c, a_err, e_err); end
            n_cmp++; if ({a_cyc, a_stb, a_cpu} !== {e_cyc, e_stb, e_cpu}) begin n_fail++; $display("FAIL rnd_ctl: c%0d cyc/stb/cpu got %b want %b", c, {a_cyc, a_stb, a_cpu}, {e_cyc, e_stb, e_cpu}); end
            n_cmp++; if ({a_addr, a_data, a_we} !== {e_addr, e_data, e_we}) begin n_fail++; $display("FAIL rnd_bus: c%0d got %h/%h/%b want %h/%h/%b", c, a_addr, a_data, a_we, e_addr, e_data, e_we); end
            n_cmp++; if (a_slot !== 3'(m_slot)) begin n_fail++; $display("FAIL rnd_slot: c%0d got %0d want %0d", c, a_slot, m_slot); end
            if (clk8_en) m_slot = (m_slot + 1) % 8;
            m_en = clk8_en;
        end
    endtask

    initial begin
        test_reset();
        test_cpu_grant();
        test_ack_latency();
        test_donate();
        test_timeout();
        test_cpu_abort();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
